// File: rtl/mul_iter.sv
// Iterative radix-2 shift-add multiplier for the RV64 M-extension multiply group
// (MUL, MULH, MULHSU, MULHU, MULW). Operates on operand magnitudes in a
// 2*XLEN accumulator and applies the product sign once, on the final iteration.
// Valid/ready handshakes on both sides; flush aborts any in-flight operation.
module mul_iter #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] data_a,
  input  logic [XLEN-1:0] data_b,
  input  logic [1:0]      mul_op,
  input  logic            alu_result_size,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int HW = XLEN / 2;
  localparam int AW = 2 * XLEN;
  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [1:0]      OP_MUL    = 2'b00;
  localparam logic [1:0]      OP_MULH   = 2'b01;
  localparam logic [1:0]      OP_MULHSU = 2'b10;
  localparam logic [XLEN-1:0] ONE_X     = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]   ONE_A     = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   CNT_FULL  = CW'(XLEN);
  localparam logic [CW-1:0]   CNT_HALF  = CW'(HW);
  localparam logic [CW-1:0]   CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [XLEN-1:0] result_q;
  logic [AW-1:0]   acc_q;
  logic [AW-1:0]   mcand_q;
  logic [XLEN-1:0] mplier_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_q;
  logic [1:0]      op_q;
  logic            word_q;

  logic [XLEN-1:0] a_ext_d, b_ext_d, a_mag_d, b_mag_d;
  logic            a_neg_d, b_neg_d;
  logic [AW-1:0]   acc_d, acc_fix_d;
  logic [XLEN-1:0] slice_d;

  // Operand preparation: word-mode sign extension, signedness per op, magnitudes.
  always_comb begin
    if (alu_result_size) begin
      a_ext_d = {{HW{data_a[HW-1]}}, data_a[HW-1:0]};
      b_ext_d = {{HW{data_b[HW-1]}}, data_b[HW-1:0]};
      a_neg_d = data_a[HW-1];
      b_neg_d = data_b[HW-1];
    end else begin
      a_ext_d = data_a;
      b_ext_d = data_b;
      a_neg_d = data_a[XLEN-1] & ((mul_op == OP_MULH) | (mul_op == OP_MULHSU));
      b_neg_d = data_b[XLEN-1] & (mul_op == OP_MULH);
    end
    // -2^63 maps to magnitude 0x8000..0, which is correct read as unsigned
    if (a_neg_d) begin
      a_mag_d = (~a_ext_d) + ONE_X;
    end else begin
      a_mag_d = a_ext_d;
    end
    if (b_neg_d) begin
      b_mag_d = (~b_ext_d) + ONE_X;
    end else begin
      b_mag_d = b_ext_d;
    end
  end

  // One shift-add step, plus sign fix-up and slice selection for the final step.
  always_comb begin
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end else begin
      acc_d = acc_q;
    end
    if (neg_q) begin
      acc_fix_d = (~acc_d) + ONE_A;
    end else begin
      acc_fix_d = acc_d;
    end
    if (word_q) begin
      slice_d = {{HW{acc_fix_d[HW-1]}}, acc_fix_d[HW-1:0]};
    end else begin
      case (op_q)
        OP_MUL:                  slice_d = acc_fix_d[XLEN-1:0];
        2'b01, 2'b10, 2'b11:     slice_d = acc_fix_d[AW-1:XLEN];
        default:                 slice_d = acc_fix_d[XLEN-1:0];
      endcase
    end
  end

  // Control FSM and datapath registers; flush outranks everything but reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      op_q        <= 2'b00;
      word_q      <= 1'b0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            state_q    <= S_BUSY;
            in_ready_q <= 1'b0;
            acc_q      <= '0;
            mcand_q    <= {{XLEN{1'b0}}, a_mag_d};
            mplier_q   <= b_mag_d;
            neg_q      <= a_neg_d ^ b_neg_d;
            op_q       <= mul_op;
            word_q     <= alu_result_size;
            cnt_q      <= alu_result_size ? CNT_HALF : CNT_FULL;
          end
        end
        S_BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= {mcand_q[AW-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[XLEN-1:1]};
          cnt_q    <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            result_q    <= slice_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_mul_iter.sv
// Self-checking bench for mul_iter: directed vector table, hand-written
// handshake/flush/reset sequences, and random ops against an arithmetic model.
module tb_mul_iter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] data_a = 64'd0;
  logic [63:0] data_b = 64'd0;
  logic [1:0]  mul_op = 2'b00;
  logic        alu_result_size = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  mul_iter #(.XLEN(64)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .data_a(data_a), .data_b(data_b), .mul_op(mul_op),
    .alu_result_size(alu_result_size), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  op;
    logic        word;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: sign/zero-extend to 128 bits and multiply (mod 2^128).
  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] op, input logic word);
    logic [127:0] ea, eb, p;
    logic [63:0]  pw;
    if (word) begin
      pw = {{32{a[31]}}, a[31:0]} * {{32{b[31]}}, b[31:0]};
      return {{32{pw[31]}}, pw[31:0]};
    end
    ea = (op == 2'b01 || op == 2'b10) ? {{64{a[63]}}, a} : {64'd0, a};
    eb = (op == 2'b01) ? {{64{b[63]}}, b} : {64'd0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[63:0] : p[127:64];
  endfunction

  // Issue one op, scramble inputs while busy, wait for result, hand it off.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op,
                        input logic word, output logic [63:0] res, output int lat);
    chk("accept_in_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; data_a = a; data_b = b; mul_op = op; alu_result_size = word;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      data_a = {$urandom, $urandom};
      data_b = {$urandom, $urandom};
      mul_op = 2'($urandom_range(0, 3));
      alu_result_size = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      lat++;
    end
    res = result;
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk("handoff_out_valid", {63'd0, out_valid}, 64'd0);
    chk("handoff_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [63:0] res, last_res, ra, rb;
    logic [1:0]  rop;
    logic        rw;
    int          lat;

    vecs[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64};
    vecs[1]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 1'b0, 64'h0, 64};
    vecs[2]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0, 64'h1, 64};
    vecs[3]  = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0, 64'h8000_0000_0000_0000, 64};
    vecs[4]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64};
    vecs[5]  = '{64'h2, 64'h3, 2'b10, 1'b0, 64'h0, 64};
    vecs[6]  = '{64'hDEAD_BEEF_7FFF_FFFF, 64'hDEAD_BEEF_0000_0002, 2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 32};
    vecs[7]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b01, 1'b0, 64'h4000_0000_0000_0000, 64};
    vecs[8]  = '{64'h0, 64'h0, 2'b00, 1'b0, 64'h0, 64};
    vecs[9]  = '{64'h3, 64'h5, 2'b00, 1'b0, 64'hF, 64};
    vecs[10] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 1'b0, 64'h0, 64};
    vecs[11] = '{64'h1234_5678_FFFF_FFFD, 64'h0000_0000_0000_0007, 2'b11, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 32};

    // reset state
    #12;
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_result", result, 64'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    // directed vectors
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].word, res, lat);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    // back-pressure in DONE
    in_valid = 1'b1; data_a = 64'd3; data_b = 64'd5; mul_op = 2'b00; alu_result_size = 1'b0;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    chk("bp_latency", 64'(lat), 64'd64);
    in_valid = 1'b1; data_a = 64'd7; data_b = 64'd7;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); #1;
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_result", result, 64'hF);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
    chk("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
    last_res = 64'hF;

    // flush at BUSY iteration 20, with a request offered in the flush cycle
    in_valid = 1'b1; data_a = 64'hFFFF_FFFF_FFFF_FFFF; data_b = 64'hFFFF_FFFF_FFFF_FFFF; mul_op = 2'b11;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (19) begin
      @(posedge clock); #1;
    end
    flush = 1'b1; in_valid = 1'b1; data_a = 64'd7; data_b = 64'd9; mul_op = 2'b00;
    @(posedge clock); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    chk("flush_result_kept", result, last_res);
    repeat (70) begin
      @(posedge clock); #1;
    end
    chk("flush_no_late_valid", {63'd0, out_valid}, 64'd0);
    run_op(64'd3, 64'd5, 2'b00, 1'b0, res, lat);
    chk("post_flush_result", res, 64'hF);
    chk("post_flush_latency", 64'(lat), 64'd64);

    // asynchronous reset mid-BUSY
    in_valid = 1'b1; data_a = 64'd11; data_b = 64'd13; mul_op = 2'b00; alu_result_size = 1'b0;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (10) begin
      @(posedge clock); #1;
    end
    #2 reset = 1'b0;
    #1;
    chk("midreset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midreset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midreset_result", result, 64'd0);
    #2 reset = 1'b1;
    @(posedge clock); #1;
    run_op(64'd6, 64'd7, 2'b00, 1'b0, res, lat);
    chk("post_reset_result", res, 64'd42);

    // random ops against the arithmetic model
    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 3))
        0: ra = 64'h8000_0000_0000_0000;
        1: ra = 64'hFFFF_FFFF_FFFF_FFFF;
        default: ra = {$urandom, $urandom};
      endcase
      rb  = ($urandom_range(0, 4) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      rop = 2'($urandom_range(0, 3));
      rw  = ($urandom_range(0, 3) == 0);
      run_op(ra, rb, rop, rw, res, lat);
      chk($sformatf("rand%0d_result(a=%h b=%h op=%0d w=%0d)", r, ra, rb, rop, rw),
          res, ref_mul(ra, rb, rop, rw));
      chk($sformatf("rand%0d_latency", r), 64'(lat), rw ? 64'd32 : 64'd64);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
